// File: rtl/lsu_if.sv
// Core-side load/store bus of the LSU: effective address, store data,
// access control and the combinational load/misalignment results.
interface lsu_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [2:0]  i_lsu_size;
  logic [31:0] o_ld_data;
  logic        o_misaligned;

  modport master (
    output i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_size,
    input  o_ld_data, o_misaligned
  );

  modport slave (
    input  i_lsu_addr, i_st_data, i_lsu_wren, i_lsu_size,
    output o_ld_data, o_misaligned
  );
endinterface

// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LED/HEX/LCD output
// registers and SW/BTN inputs. Loads are combinational, stores commit on
// the rising edge. Optional macro LSU_INPUT_SYNC_EN inserts a two-flop
// synchronizer on the switch and button inputs.
module lsu #(
  parameter int unsigned DMEM_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lsu_if.slave        bus,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  localparam int unsigned IDX_W = $clog2(DMEM_WORDS);

  logic [31:0]      mem [DMEM_WORDS];
  logic [6:0]       hex_q [8];
  logic [31:0]      sw_rd;
  logic [3:0]       btn_rd;
  logic [19:0]      page;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic in_dmem, sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, sel_sw, sel_btn;
  logic mapped, is_byte, is_half, is_uns, mis_c, store_ok;
  logic [3:0]  be;
  logic [31:0] wdata, rd_word, shifted;

  // Address and access-size decode
  assign page      = bus.i_lsu_addr[31:12];
  assign lane      = bus.i_lsu_addr[1:0];
  assign idx       = bus.i_lsu_addr[IDX_W+1:2];
  assign in_dmem   = (bus.i_lsu_addr[31:IDX_W+2] == '0);
  assign sel_ledr  = (page == 20'h10000);
  assign sel_ledg  = (page == 20'h10001);
  assign sel_hexlo = (page == 20'h10002);
  assign sel_hexhi = (page == 20'h10003);
  assign sel_lcd   = (page == 20'h10004);
  assign sel_sw    = (page == 20'h10010);
  assign sel_btn   = (page == 20'h10011);
  assign mapped    = in_dmem | sel_ledr | sel_ledg | sel_hexlo | sel_hexhi |
                     sel_lcd | sel_sw | sel_btn;
  assign is_byte   = (bus.i_lsu_size == 3'b000) || (bus.i_lsu_size == 3'b100);
  assign is_half   = (bus.i_lsu_size == 3'b001) || (bus.i_lsu_size == 3'b101);
  assign is_uns    = bus.i_lsu_size[2];
  assign mis_c     = (is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00));
  assign store_ok  = bus.i_lsu_wren & mapped & ~mis_c;
  assign bus.o_misaligned = mapped & mis_c;

  // Byte enables and lane-replicated store data
  always_comb begin
    be    = 4'b1111;
    wdata = bus.i_st_data;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{bus.i_st_data[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.i_st_data[15:0]}};
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] en);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = en[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

`ifdef LSU_INPUT_SYNC_EN
  logic [31:0] sw_meta, sw_sync;
  logic [3:0]  btn_meta, btn_sync;

  // Two-flop synchronizer for the asynchronous switch/button pins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= i_io_sw;
      sw_sync  <= sw_meta;
      btn_meta <= i_io_btn;
      btn_sync <= btn_meta;
    end
  end

  assign sw_rd  = sw_sync;
  assign btn_rd = btn_sync;
`else
  assign sw_rd  = i_io_sw;
  assign btn_rd = i_io_btn;
`endif

  // Data memory: byte-lane writes, no reset, store dropped under reset
  always_ff @(posedge i_clk) begin
    if (!i_reset && store_ok && in_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Output registers; HEX keeps only the low 7 bits of each byte lane
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_io_ledr <= '0;
      o_io_ledg <= '0;
      o_io_lcd  <= '0;
      for (int n = 0; n < 8; n++) hex_q[n] <= '0;
    end else if (store_ok) begin
      if (sel_ledr) o_io_ledr <= merge(o_io_ledr, wdata, be);
      if (sel_ledg) o_io_ledg <= merge(o_io_ledg, wdata, be);
      if (sel_lcd)  o_io_lcd  <= merge(o_io_lcd, wdata, be);
      for (int n = 0; n < 4; n++) begin
        if (sel_hexlo && be[n]) hex_q[n]     <= wdata[8*n +: 7];
        if (sel_hexhi && be[n]) hex_q[n + 4] <= wdata[8*n +: 7];
      end
    end
  end

  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];

  // Read-word select by region
  always_comb begin
    rd_word = '0;
    if (in_dmem)        rd_word = mem[idx];
    else if (sel_ledr)  rd_word = o_io_ledr;
    else if (sel_ledg)  rd_word = o_io_ledg;
    else if (sel_hexlo) rd_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
    else if (sel_hexhi) rd_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
    else if (sel_lcd)   rd_word = o_io_lcd;
    else if (sel_sw)    rd_word = sw_rd;
    else if (sel_btn)   rd_word = {28'b0, btn_rd};
  end

  // Lane extraction with sign/zero extension
  always_comb begin
    shifted       = rd_word >> {lane, 3'b000};
    bus.o_ld_data = shifted;
    if (!mapped || mis_c)
      bus.o_ld_data = '0;
    else if (is_byte)
      bus.o_ld_data = is_uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      bus.o_ld_data = is_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan steps followed by
// randomized accesses compared against a byte-level reference model.
module tb_lsu;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] sw_pin;
  logic [3:0]  btn_pin;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_if bus();

  lsu #(.DMEM_WORDS(512)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus), .i_io_sw(sw_pin), .i_io_btn(btn_pin),
    .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(lcd)
  );

  // Reference model state
  logic [7:0]  m_mem [int];
  logic [31:0] m_ledr, m_ledg, m_lcd;
  logic [6:0]  m_hex [8];
  logic [31:0] s1_sw, s2_sw;
  logic [3:0]  s1_btn, s2_btn;

  function automatic int region(input logic [31:0] a);
    if (a < 32'd2048) return 1;
    case (a[31:12])
      20'h10000: return 2;
      20'h10001: return 3;
      20'h10002: return 4;
      20'h10003: return 5;
      20'h10004: return 6;
      20'h10010: return 7;
      20'h10011: return 8;
      default:   return 0;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] view_sw();
`ifdef LSU_INPUT_SYNC_EN
    return s2_sw;
`else
    return sw_pin;
`endif
  endfunction

  function automatic logic [3:0] view_btn();
`ifdef LSU_INPUT_SYNC_EN
    return s2_btn;
`else
    return btn_pin;
`endif
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    int k = int'(a % 4);
    logic [31:0] w;
    case (region(a))
      1: return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 8'hxx;
      2: begin w = m_ledr; return w[8*k +: 8]; end
      3: begin w = m_ledg; return w[8*k +: 8]; end
      4: return {1'b0, m_hex[k]};
      5: return {1'b0, m_hex[k + 4]};
      6: begin w = m_lcd; return w[8*k +: 8]; end
      7: begin w = view_sw(); return w[8*k +: 8]; end
      8: return (k == 0) ? {4'b0, view_btn()} : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_mis(input logic [31:0] a, input logic [2:0] s);
    return (region(a) != 0) && ((a % nbytes(s)) != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] s);
    logic [31:0] v = 32'h0;
    int n = nbytes(s);
    if (region(a) == 0 || exp_mis(a, s)) return 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(rd_byte(a + 32'(i))) << (8 * i));
    if (s == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (s == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
    int k = int'(a % 4);
    case (region(a))
      1: m_mem[int'(a)] = b;
      2: m_ledr[8*k +: 8] = b;
      3: m_ledg[8*k +: 8] = b;
      4: m_hex[k] = b[6:0];
      5: m_hex[k + 4] = b[6:0];
      6: m_lcd[8*k +: 8] = b;
      default: ;
    endcase
  endtask

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    if (region(a) == 0 || exp_mis(a, s)) return;
    for (int i = 0; i < nbytes(s); i++) wr_byte(a + 32'(i), d[8*i +: 8]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the bus just after a falling edge and let the comb paths settle
  task automatic setio(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [2:0] s);
    bus.i_lsu_addr = a;
    bus.i_st_data  = d;
    bus.i_lsu_wren = w;
    bus.i_lsu_size = s;
    #1;
  endtask

  task automatic ld_chk(input string tag);
    chk({tag, "_ld"}, bus.o_ld_data, exp_load(bus.i_lsu_addr, bus.i_lsu_size));
    chk({tag, "_mis"}, 32'(bus.o_misaligned),
        32'(exp_mis(bus.i_lsu_addr, bus.i_lsu_size)));
  endtask

  // One rising edge: the model commits what the DUT sees at that edge
  task automatic clk_step;
    @(posedge clk);
    if (rst) begin
      m_ledr = '0; m_ledg = '0; m_lcd = '0;
      for (int i = 0; i < 8; i++) m_hex[i] = '0;
      s1_sw = '0; s2_sw = '0; s1_btn = '0; s2_btn = '0;
    end else begin
      if (bus.i_lsu_wren) m_store(bus.i_lsu_addr, bus.i_st_data, bus.i_lsu_size);
      s2_sw = s1_sw; s1_sw = sw_pin;
      s2_btn = s1_btn; s1_btn = btn_pin;
    end
    @(negedge clk);
  endtask

  task automatic regs_chk(input string tag);
    chk({tag, "_ledr"}, ledr, m_ledr);
    chk({tag, "_ledg"}, ledg, m_ledg);
    chk({tag, "_lcd"}, lcd, m_lcd);
    chk({tag, "_hexlo"}, {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0},
        {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]});
    chk({tag, "_hexhi"}, {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4},
        {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]});
  endtask

  logic [31:0] bases [7];
  logic [31:0] a;

  initial begin
    bases[0] = 32'h1000_0000; bases[1] = 32'h1000_1000; bases[2] = 32'h1000_2000;
    bases[3] = 32'h1000_3000; bases[4] = 32'h1000_4000; bases[5] = 32'h1001_0000;
    bases[6] = 32'h1001_1000;
    m_ledr = '0; m_ledg = '0; m_lcd = '0;
    for (int i = 0; i < 8; i++) m_hex[i] = '0;
    s1_sw = '0; s2_sw = '0; s1_btn = '0; s2_btn = '0;
    rst = 1'b1; sw_pin = '0; btn_pin = '0;
    @(negedge clk);
    setio(32'h0, 32'h0, 1'b0, 3'd2);
    clk_step();
    clk_step();
    rst = 1'b0;
    regs_chk("reset");
    for (int i = 0; i < 5; i++) begin
      setio(bases[i], 32'h0, 1'b0, 3'd2);
      chk("reset_rd", bus.o_ld_data, 32'h0);
    end

    // Initialise the DMEM window used below plus the last word
    for (int i = 0; i < 16; i++) begin
      setio(32'(4 * i), 32'h0, 1'b1, 3'd2);
      clk_step();
    end
    setio(32'h7FC, 32'h0, 1'b1, 3'd2);
    clk_step();

    setio(32'h10, 32'h1234_5678, 1'b1, 3'd2); clk_step();
    setio(32'h10, 32'h0, 1'b0, 3'd2);
    chk("lw_word", bus.o_ld_data, 32'h1234_5678);
    setio(32'h11, 32'hAB, 1'b1, 3'd0);
    chk("raw_old", bus.o_ld_data, 32'h0000_0056);
    clk_step();
    setio(32'h10, 32'h0, 1'b0, 3'd2);
    chk("sb_merge", bus.o_ld_data, 32'h1234_AB78);
    setio(32'h11, 32'h0, 1'b0, 3'd0);
    chk("lb", bus.o_ld_data, 32'hFFFF_FFAB);
    setio(32'h11, 32'h0, 1'b0, 3'd4);
    chk("lbu", bus.o_ld_data, 32'h0000_00AB);

    setio(32'h22, 32'h8001, 1'b1, 3'd1); clk_step();
    setio(32'h22, 32'h0, 1'b0, 3'd1);
    chk("lh", bus.o_ld_data, 32'hFFFF_8001);
    setio(32'h22, 32'h0, 1'b0, 3'd5);
    chk("lhu", bus.o_ld_data, 32'h0000_8001);

    setio(32'h1000_2000, 32'h7F3F_067F, 1'b1, 3'd2); clk_step();
    chk("hex0", 32'(hex0), 32'h7F);
    chk("hex1", 32'(hex1), 32'h06);
    chk("hex2", 32'(hex2), 32'h3F);
    chk("hex3", 32'(hex3), 32'h7F);
    setio(32'h1000_2000, 32'h0, 1'b0, 3'd2);
    chk("hex_rd", bus.o_ld_data, 32'h7F3F_067F);

    setio(32'h2, 32'hFFFF_FFFF, 1'b1, 3'd2);
    chk("mis_sw", 32'(bus.o_misaligned), 32'h1);
    clk_step();
    setio(32'h0, 32'h0, 1'b0, 3'd2);
    chk("mis_keep", bus.o_ld_data, 32'h0);
    setio(32'h1, 32'h0, 1'b0, 3'd1);
    chk("mis_lh", bus.o_ld_data, 32'h0);
    chk("mis_lh_flag", 32'(bus.o_misaligned), 32'h1);
    setio(32'h2000_0000, 32'h0, 1'b0, 3'd2);
    chk("unmap_ld", bus.o_ld_data, 32'h0);
    chk("unmap_mis", 32'(bus.o_misaligned), 32'h0);

    setio(32'h1001_0000, 32'h0, 1'b0, 3'd2);
    sw_pin = 32'hDEAD_BEEF; #1;
`ifdef LSU_INPUT_SYNC_EN
    chk("sync_e0", bus.o_ld_data, 32'h0);
    clk_step();
    chk("sync_e1", bus.o_ld_data, 32'h0);
    clk_step();
`else
    chk("sync_e0", bus.o_ld_data, 32'hDEAD_BEEF);
    clk_step();
    chk("sync_e1", bus.o_ld_data, 32'hDEAD_BEEF);
    clk_step();
`endif
    chk("sync_e2", bus.o_ld_data, 32'hDEAD_BEEF);
    btn_pin = 4'b1010;
    clk_step(); clk_step();
    setio(32'h1001_1000, 32'h0, 1'b0, 3'd2);
    chk("btn", bus.o_ld_data, 32'h0000_000A);

    // Reset beats a simultaneous store
    setio(32'h1000_0000, 32'h5555_5555, 1'b1, 3'd2); clk_step();
    rst = 1'b1;
    setio(32'h30, 32'hCAFE_F00D, 1'b1, 3'd2); clk_step();
    rst = 1'b0;
    setio(32'h30, 32'h0, 1'b0, 3'd2);
    chk("rst_dmem", bus.o_ld_data, 32'h0);
    chk("rst_ledr", ledr, 32'h0);
    regs_chk("rst_store");

    // Randomized accesses against the model
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 63));
        4:          a = 32'h7FC + 32'($urandom_range(0, 3));
        5:          a = 32'h800 + 32'($urandom_range(0, 15));
        6:          a = 32'h2000_0000 + 32'($urandom_range(0, 4095));
        default:    a = bases[$urandom_range(0, 6)] | 32'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 7) == 0) sw_pin = $urandom;
      if ($urandom_range(0, 7) == 0) btn_pin = 4'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      setio(a, $urandom, 1'($urandom), 3'($urandom));
      ld_chk("rnd");
      clk_step();
      regs_chk("rnd");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load-store unit of the single-cycle RV32I core: owns the data memory and the memory-mapped I/O registers (LEDs, seven-segment digits, LCD, switches, buttons). It sits between the ALU, which supplies the effective address, and the write-back select mux. Its `o_ld_data` drives the mux input selected by code `2'b01`. Loads complete combinationally in the same cycle; stores commit on the rising clock edge.

## Interface
- `DMEM_WORDS`, default 512: data memory depth in 32-bit words. Must be a power of two, at most 1024.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_lsu_addr`  in  32  byte address from the ALU.
- `i_st_data`  in  32  store data (rs2).
- `i_lsu_wren`  in  1  1 = store this cycle, 0 = load/idle.
- `i_lsu_size`  in  3  funct3. Codes:
  - 000 byte, 001 half, 010 word.
  - 100 byte unsigned, 101 half unsigned.
  - Any other code is treated as a word access.
- `i_io_sw`  in  32  switch inputs.
- `i_io_btn`  in  4  push-button inputs.
- `o_ld_data`  out  32  load result, sign- or zero-extended.
- `o_io_ledr`  out  32  red LED register.
- `o_io_ledg`  out  32  green LED register.
- `o_io_hex0` .. `o_io_hex7`  out  7 each  seven-segment digit registers.
- `o_io_lcd`  out  32  LCD control register.
- `o_misaligned`  out  1  current access is misaligned (combinational).

## Operation
- Address map. The register regions decode on `addr[31:12]`; all word offsets inside a region alias the same register.
  - DMEM: 0x0000_0000 .. 4*DMEM_WORDS-1.
  - LEDR: 0x1000_0000.
  - LEDG: 0x1000_1000.
  - HEX lo (digits 0-3): 0x1000_2000.
  - HEX hi (digits 4-7): 0x1000_3000.
  - LCD: 0x1000_4000.
  - SW (read-only): 0x1001_0000.
  - BTN (read-only): 0x1001_1000; value is `{28'b0, btn}`.
- HEX word layout: the digit at byte lane n occupies bits [8n+6:8n]. Bit 8n+7 is not stored and reads as 0.
- Byte lanes come from `addr[1:0]`.
  - Byte access: any lane.
  - Half access: lane 0 or 2.
  - Word access: lane 0 only.
- A store writes only the addressed lanes. The other bytes of the target word keep their value.
- Load result: the addressed byte or half, right-justified.
  - Sign-extended for codes 000 and 001; zero-extended for 100 and 101.
  - Word loads return the full word.
- Misaligned access (half with `addr[0]=1`, or word with `addr[1:0]!=0`):
  - `o_misaligned=1`.
  - A store is suppressed.
  - A load returns 0.
- Unmapped address: loads return 0. Stores are ignored. `o_misaligned` is not asserted.
- Stores to SW or BTN are ignored.
- Loads of output registers return their current contents.

## Timing
- Load: combinational. `o_ld_data` is valid in the same cycle as the address.
- Store: takes effect on the rising edge at which `i_lsu_wren=1`.
- Read-after-write:
  - A load of an address in the same cycle as a store to it returns the old value.
  - A load in the next cycle returns the new value.
- Reset, on the rising edge with `i_reset=1`:
  - Clears `o_io_ledr`, `o_io_ledg`, all HEX digits and `o_io_lcd` to 0.
  - Clears the input synchronizers to 0.
  - Does not clear DMEM; its contents are undefined until written.
- Reset has priority over a simultaneous store: the I/O registers end at 0, and a DMEM store in that cycle is discarded.
- `o_misaligned` and `o_ld_data` are combinational and are not affected by reset beyond the synchronizer contents.

## Configuration
- `LSU_INPUT_SYNC_EN` defined:
  - `i_io_sw` and `i_io_btn` pass through a two-flop synchronizer before reaching the read path.
  - A change on a pin becomes visible to loads 2 rising edges later.
  - Synchronizers reset to 0.
- `LSU_INPUT_SYNC_EN` undefined: SW and BTN loads read the pins combinationally, with zero latency. No extra flops.

## Test plan
- Reset, then load LEDR, LEDG, HEX lo, HEX hi and LCD -> all read 0x0000_0000.
- SW 0x1234_5678 at 0x0000_0010, then LW from the same address -> 0x1234_5678.
  - SB 0xAB to 0x0000_0011, then LW -> 0x1234_AB78.
  - LB from 0x0000_0011 -> 0xFFFF_FFAB; LBU -> 0x0000_00AB.
- SH 0x8001 to 0x0000_0022, then:
  - LH from 0x0000_0022 -> 0xFFFF_8001.
  - LHU -> 0x0000_8001.
- SW 0x7F3F_067F to HEX lo -> `o_io_hex0`=0x7F, `o_io_hex1`=0x06, `o_io_hex2`=0x3F, `o_io_hex3`=0x7F.
  - LW from HEX lo -> 0x7F3F_067F.
- Misaligned and unmapped accesses:
  - SW to 0x0000_0002 -> `o_misaligned=1`; the word at 0x0000_0000 is unchanged.
  - LH from 0x0000_0001 -> 0.
  - LW from 0x2000_0000 -> 0, with `o_misaligned=0`.
- Input synchronizer:
  - With `LSU_INPUT_SYNC_EN`: drive `i_io_sw`=0xDEAD_BEEF; load SW each cycle -> 0 after 1 edge, 0xDEAD_BEEF after 2 edges.
  - Without the macro: 0xDEAD_BEEF in the same cycle.
  - BTN=4'b1010 reads 0x0000_000A.
